// File: rtl/encode_fp_pkg.sv
// rtl/encode_fp_pkg.sv - shared fp field widths, scale constant and FSM encodings
package encode_fp_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int DIVISOR = 100;
    localparam int FP_W    = 1 + EXP_W + MAN_W;

    typedef enum logic [5:0] {
        S_INIT  = 6'b000001,
        S_LOAD  = 6'b000010,
        S_NORM  = 6'b000100,
        S_DIV   = 6'b001000,
        S_ROUND = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/encode_fp_if.sv
// rtl/encode_fp_if.sv - request/response handshake between a producer and encode_fp
interface encode_fp_if;
    import encode_fp_pkg::*;

    logic            start;
    logic            ack;
    logic [3:0]      digit_1;
    logic [3:0]      digit_2;
    logic [FP_W-1:0] fp_out;
    logic            done;
    logic            busy;

    modport master (
        output start, ack, digit_1, digit_2,
        input  fp_out, done, busy
    );

    modport slave (
        input  start, ack, digit_1, digit_2,
        output fp_out, done, busy
    );
endinterface

// File: rtl/encode_fp_bcd2_to_bin.sv
// rtl/encode_fp_bcd2_to_bin.sv - clamp two BCD digits and form 10*D1 + D2
module bcd2_to_bin
    import encode_fp_pkg::*;
(
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_2,
    output logic [6:0] bin
);
    logic [6:0] tens;
    logic [6:0] units;

    always_comb begin
        tens  = {3'b000, clamp_bcd(digit_1)};
        units = {3'b000, clamp_bcd(digit_2)};
        // 10*x as 8*x + 2*x; max 99 fits in 7 bits
        bin   = (tens << 3) + (tens << 1) + units;
    end
endmodule

// File: rtl/encode_fp.sv
// rtl/encode_fp.sv - BCD fraction 0.D1D2 to binary16 (RNE), one shift or quotient bit per clock
module encode_fp
    import encode_fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    encode_fp_if.slave   bus
);
    state_t          state;
    logic [3:0]      d1_q;
    logic [3:0]      d2_q;
    logic [7:0]      rem;
    logic [2:0]      k;
    logic [MAN_W:0]  quo;
    logic [3:0]      bit_cnt;
    logic            is_zero;
    logic [FP_W-1:0] fp_out_q;
    logic            done_q;
    logic            busy_q;

    logic [6:0]       n_bin;
    logic [7:0]       rem_sh;
    logic             div_ge;
    logic             round_up;
    logic [MAN_W:0]   man_sum;
    logic [EXP_W-1:0] exp_out;

    bcd2_to_bin u_bcd2_to_bin (
        .digit_1 (d1_q),
        .digit_2 (d2_q),
        .bin     (n_bin)
    );

    // rem stays below DIVISOR in NORM/DIV, so the doubled value fits in 8 bits
    always_comb begin
        rem_sh   = {rem[6:0], 1'b0};
        div_ge   = (rem_sh >= 8'(DIVISOR));
        round_up = quo[0] & ((rem != 8'd0) | quo[1]);
        man_sum  = {1'b0, quo[MAN_W:1]} + {{MAN_W{1'b0}}, round_up};
        exp_out  = 5'(BIAS) - {2'b00, k} + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            d1_q     <= '0;
            d2_q     <= '0;
            rem      <= '0;
            k        <= '0;
            quo      <= '0;
            bit_cnt  <= '0;
            is_zero  <= 1'b0;
            fp_out_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (bus.start) begin
                        d1_q   <= bus.digit_1;
                        d2_q   <= bus.digit_2;
                        busy_q <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rem     <= {1'b0, n_bin};
                    k       <= '0;
                    quo     <= '0;
                    bit_cnt <= '0;
                    is_zero <= (n_bin == 7'd0);
                    state   <= (n_bin == 7'd0) ? S_ROUND : S_NORM;
                end
                S_NORM: begin
                    if (rem < 8'(DIVISOR)) begin
                        rem <= rem_sh;
                        k   <= k + 3'd1;
                    end else begin
                        // the leading 1 becomes the implicit bit
                        rem   <= rem - 8'(DIVISOR);
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem     <= div_ge ? (rem_sh - 8'(DIVISOR)) : rem_sh;
                    quo     <= {quo[MAN_W-1:0], div_ge};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'(MAN_W))
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    fp_out_q <= is_zero ? '0 : {1'b0, exp_out, man_sum[MAN_W-1:0]};
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (bus.ack) begin
                        done_q <= 1'b0;
                        state  <= S_INIT;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.fp_out = fp_out_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_encode_fp.sv
// tb/tb_encode_fp.sv - directed vectors and full digit sweep for encode_fp
module tb_encode_fp;
    logic sys_clk_tb = 1'b0;
    logic rst_n_tb   = 1'b0;
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   lat;

    always #5 sys_clk_tb = ~sys_clk_tb;

    encode_fp_if bus_if ();

    encode_fp dut (
        .clk   (sys_clk_tb),
        .rst_n (rst_n_tb),
        .bus   (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_k(input int n);
        int kk = 0;
        while ((n << kk) < 100) kk++;
        return kk;
    endfunction

    // exact RNE of n/100 in binary16 via wide integer division
    function automatic logic [15:0] ref_fp(input int n);
        longint num, q, r;
        int kk, e;
        if (n == 0) return 16'h0000;
        kk  = ref_k(n);
        num = longint'(n) << (10 + kk);
        q   = num / 100;
        r   = num % 100;
        if ((r * 2 > 100) || ((r * 2 == 100) && (q % 2 == 1))) q++;
        e = 15 - kk;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        return {1'b0, 5'(e), 10'(q)};
    endfunction

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40 && !bus_if.done; i++) begin
            @(posedge sys_clk_tb);
            #1;
            cycles++;
        end
    endtask

    task automatic do_ack(input string tag);
        bus_if.ack = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        bus_if.ack = 1'b0;
        check({tag, "_done_after_ack"}, 32'(bus_if.done), 32'd0);
    endtask

    // enters and leaves just after a rising edge
    task automatic run_conv(input string tag, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [15:0] exp_fp, input int exp_lat);
        int c;
        bus_if.digit_1 = d1;
        bus_if.digit_2 = d2;
        bus_if.start   = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        bus_if.start = 1'b0;
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
        wait_done(c);
        check({tag, "_done"}, 32'(bus_if.done), 32'd1);
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(c), 32'(exp_lat));
        check({tag, "_fp"}, 32'(bus_if.fp_out), 32'(exp_fp));
        do_ack(tag);
    endtask

    initial begin
        int c;
        bus_if.start   = 1'b0;
        bus_if.ack     = 1'b0;
        bus_if.digit_1 = 4'd0;
        bus_if.digit_2 = 4'd0;
        repeat (3) @(posedge sys_clk_tb);
        #1;
        check("rst_fp", 32'(bus_if.fp_out), 32'h0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        @(negedge sys_clk_tb);
        rst_n_tb = 1'b1;
        @(posedge sys_clk_tb);
        #1;

        // 0.20 with Done held until Ack
        bus_if.digit_1 = 4'd2;
        bus_if.digit_2 = 4'd0;
        bus_if.start   = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        bus_if.start = 1'b0;
        wait_done(c);
        check("p20_latency", 32'(c), 32'd17);
        check("p20_fp", 32'(bus_if.fp_out), 32'h3266);
        repeat (5) @(posedge sys_clk_tb);
        #1;
        check("p20_done_held", 32'(bus_if.done), 32'd1);
        check("p20_busy_in_done", 32'(bus_if.busy), 32'd0);
        do_ack("p20");

        run_conv("p01", 4'd0, 4'd1, 16'h211F, 21);
        run_conv("p99", 4'd9, 4'd9, 16'h3BEC, 15);
        run_conv("p50", 4'd5, 4'd0, 16'h3800, 15);
        run_conv("p00", 4'd0, 4'd0, 16'h0000, 2);
        run_conv("clamp", 4'hC, 4'hF, 16'h3BEC, 15);

        // Start pulsed mid-DIV and again while Done without Ack
        bus_if.digit_1 = 4'd2;
        bus_if.digit_2 = 4'd0;
        bus_if.start   = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        bus_if.start = 1'b0;
        repeat (7) @(posedge sys_clk_tb);
        #1;
        bus_if.digit_1 = 4'd9;
        bus_if.digit_2 = 4'd9;
        bus_if.start   = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        bus_if.start = 1'b0;
        wait_done(c);
        check("ign_div_latency", 32'(c + 8), 32'd17);
        check("ign_div_fp", 32'(bus_if.fp_out), 32'h3266);
        bus_if.digit_1 = 4'd0;
        bus_if.digit_2 = 4'd1;
        bus_if.start   = 1'b1;
        repeat (3) @(posedge sys_clk_tb);
        #1;
        check("ign_done_fp", 32'(bus_if.fp_out), 32'h3266);
        check("ign_done_done", 32'(bus_if.done), 32'd1);
        // Ack with Start held: back to INIT, then the held Start launches 0.50
        bus_if.digit_1 = 4'd5;
        bus_if.digit_2 = 4'd0;
        bus_if.ack     = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        bus_if.ack = 1'b0;
        check("held_done_low", 32'(bus_if.done), 32'd0);
        check("held_busy_low", 32'(bus_if.busy), 32'd0);
        @(posedge sys_clk_tb);
        #1;
        bus_if.start = 1'b0;
        check("held_busy", 32'(bus_if.busy), 32'd1);
        wait_done(c);
        check("held_latency", 32'(c), 32'd15);
        check("held_fp", 32'(bus_if.fp_out), 32'h3800);
        do_ack("held");

        // asynchronous reset in the middle of DIV
        bus_if.digit_1 = 4'd2;
        bus_if.digit_2 = 4'd0;
        bus_if.start   = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        bus_if.start = 1'b0;
        repeat (8) @(posedge sys_clk_tb);
        #2;
        check("mid_busy", 32'(bus_if.busy), 32'd1);
        rst_n_tb = 1'b0;
        #1;
        check("arst_fp", 32'(bus_if.fp_out), 32'h0);
        check("arst_done", 32'(bus_if.done), 32'd0);
        check("arst_busy", 32'(bus_if.busy), 32'd0);
        @(negedge sys_clk_tb);
        rst_n_tb = 1'b1;
        @(posedge sys_clk_tb);
        #1;
        run_conv("post_rst", 4'd2, 4'd0, 16'h3266, 17);

        for (int d1 = 0; d1 < 10; d1++) begin
            for (int d2 = 0; d2 < 10; d2++) begin
                int n;
                n = 10 * d1 + d2;
                run_conv($sformatf("sweep_%0d%0d", d1, d2), 4'(d1), 4'(d2), ref_fp(n),
                         (n == 0) ? 2 : ref_k(n) + 14);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
